// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: default widths and the
// occupancy state encoding. State values equal the held-beat count so the
// state flop can drive the occupancy port directly.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 69;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready handshake bundle for pipe_stage_reg.
// Signals:
//   in_valid/in_ready/in_ctrl/in_data     - upstream beat into the stage
//   out_valid/out_ready/out_ctrl/out_data - downstream beat out of the stage
// Modports:
//   slave  - the stage's view (consumes in_*, produces out_*)
//   master - the surrounding pipeline's view
interface pipe_stage_reg_if import pipe_pkg::*; #(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One storage slot (valid + ctrl + data) of the pipeline stage.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   load             - capture ld_ctrl/ld_data and mark valid (wins over clear)
//   clear            - drop to a bubble; ctrl is zeroed, data is kept
//   ld_ctrl, ld_data - value to capture
//   valid, ctrl, data - held beat
module pipe_slot import pipe_pkg::*; #(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // ctrl is forced to zero on every bubble so a held ctrl is never stale
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, one-cycle latency,
// flush with saturating drop counter.
// Build option: PIPE_STAGE_SKID_EN adds a skid slot S so in_ready comes
// straight from a flop; without it in_ready = !M.valid | out_ready.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   flush      - kill held and incoming beats this cycle
//   bus        - handshake bundle (slave modport)
//   occupancy  - held beats (0..2)
//   drop_cnt   - saturating count of beats discarded by flush
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_reg_if.slave      bus,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int unsigned SUM_W = CNT_W + 1;

    pipe_state_e       state;
    pipe_state_e       state_nxt;
    logic              accept;
    logic              emit;
    logic              m_valid;
    logic              m_load;
    logic              m_clear;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ld_ctrl;
    logic [DATA_W-1:0] m_ld_data;
    logic              s_valid;
    logic [1:0]        drop_inc;
    logic [SUM_W-1:0]  drop_sum;
    logic [CNT_W-1:0]  drop_nxt;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_load;
    logic              s_clear;
    logic              m_from_s;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
`endif

    assign accept = bus.in_valid & bus.in_ready;
    assign emit   = m_valid & bus.out_ready;

    // Slot control and next occupancy state; flush overrides any handshake
    always_comb begin
        state_nxt = state;
        m_load    = 1'b0;
        m_clear   = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        s_load    = 1'b0;
        s_clear   = 1'b0;
        m_from_s  = 1'b0;
`endif
        if (flush) begin
            state_nxt = PIPE_EMPTY;
            m_clear   = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            s_clear   = 1'b1;
`endif
        end else begin
            case (state)
                PIPE_EMPTY: begin
                    if (accept) begin
                        m_load    = 1'b1;
                        state_nxt = PIPE_ONE;
                    end
                end
                PIPE_ONE: begin
                    if (accept && emit) begin
                        m_load = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (accept) begin
                        s_load    = 1'b1;
                        state_nxt = PIPE_FULL;
`endif
                    end else if (emit) begin
                        m_clear   = 1'b1;
                        state_nxt = PIPE_EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                PIPE_FULL: begin
                    // in_ready is low here, so only the skid beat can move
                    if (emit) begin
                        m_load    = 1'b1;
                        m_from_s  = 1'b1;
                        s_clear   = 1'b1;
                        state_nxt = PIPE_ONE;
                    end
                end
`endif
                default: state_nxt = PIPE_EMPTY;
            endcase
        end
    end

    // Beats discarded by a flush: everything held plus a same-cycle accept
    assign drop_inc = 2'(m_valid) + 2'(s_valid) + 2'(accept);
    assign drop_sum = {1'b0, drop_cnt} + SUM_W'(drop_inc);
    assign drop_nxt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PIPE_EMPTY;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                drop_cnt <= drop_nxt;
            end
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    assign m_ld_ctrl = m_from_s ? s_ctrl : bus.in_ctrl;
    assign m_ld_data = m_from_s ? s_data : bus.in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot_s (
        .clk     (clk),
        .rst     (rst),
        .load    (s_load),
        .clear   (s_clear),
        .ld_ctrl (bus.in_ctrl),
        .ld_data (bus.in_data),
        .valid   (s_valid),
        .ctrl    (s_ctrl),
        .data    (s_data)
    );

    assign bus.in_ready = ~s_valid;
`else
    assign m_ld_ctrl = bus.in_ctrl;
    assign m_ld_data = bus.in_data;
    assign s_valid   = 1'b0;

    // Without a skid slot a new beat fits only if M is free or leaving
    assign bus.in_ready = ~m_valid | bus.out_ready;
`endif

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot_m (
        .clk     (clk),
        .rst     (rst),
        .load    (m_load),
        .clear   (m_clear),
        .ld_ctrl (m_ld_ctrl),
        .ld_data (m_ld_data),
        .valid   (m_valid),
        .ctrl    (m_ctrl),
        .data    (m_data)
    );

    // M's ctrl is already zero whenever M is empty
    assign bus.out_valid = m_valid;
    assign bus.out_ctrl  = m_ctrl;
    assign bus.out_data  = m_data;
    assign occupancy     = 2'(state);

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 4: width of the control bundle (write-enable class bits), which is zeroed when the stage holds a bubble.
REQ-002 Parameter DATA_W, default 69: width of the data payload (result, store data, dest reg), which is not cleared on a bubble.
REQ-003 Parameter CNT_W, default 16: width of the drop counter.
REQ-004 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port flush, input, 1: synchronous kill of all held and incoming beats.
REQ-007 Port in_valid, input, 1: upstream beat present.
REQ-008 Port in_ready, output, 1: stage accepts a beat this cycle.
REQ-009 Port in_ctrl, input, CTRL_W: upstream control bundle.
REQ-010 Port in_data, input, DATA_W: upstream payload.
REQ-011 Port out_valid, output, 1: downstream beat present.
REQ-012 Port out_ready, input, 1: downstream accepts.
REQ-013 Port out_ctrl, output, CTRL_W: held control; all zeros whenever out_valid=0.
REQ-014 Port out_data, output, DATA_W: held payload.
REQ-015 Port occupancy, output, 2: number of held beats (0..2).
REQ-016 Port drop_cnt, output, CNT_W: saturating count of beats discarded by flush.

Function
REQ-017 Accept = in_valid & in_ready; Emit = out_valid & out_ready; latency is exactly 1 cycle; throughput is 1 beat/cycle.
REQ-018 Storage: main slot M drives the outputs; skid slot S holds one overflow beat.
REQ-019 States: EMPTY (M=0, S=0), ONE (M=1, S=0), FULL (M=1, S=1); occupancy = 0/1/2.
REQ-020 EMPTY + Accept -> ONE, with M loaded.
REQ-021 ONE + Accept + Emit -> ONE, with M loaded from the input.
REQ-022 ONE + Accept + !Emit -> FULL, with S loaded from the input.
REQ-023 ONE + !Accept + Emit -> EMPTY.
REQ-024 FULL + Emit -> ONE, with M loaded from S; FULL + !Emit holds.
REQ-025 in_ready = !S.valid, driven directly from a flop with no combinational path from out_ready.
REQ-026 out_valid = M.valid; out_ctrl = M.valid ? M.ctrl : 0; out_data = M.data.
REQ-027 flush=1 -> next state EMPTY; any beat accepted the same cycle is discarded; flush overrides Accept and Emit.
REQ-028 On flush, drop_cnt += M.valid + S.valid + Accept (0..3), saturating at all-ones, with no wrap.
REQ-029 Beat order is preserved; no beat is duplicated or lost except by flush.

Reset
REQ-030 rst=1 -> EMPTY; out_valid=0; out_ctrl=0; out_data=0; in_ready=1; occupancy=0; drop_cnt=0.
REQ-031 rst has priority over flush and over any handshake; a beat present during rst is discarded and not counted.

Configuration
REQ-032 With macro PIPE_STAGE_SKID_EN defined, REQ-018..REQ-025 apply as written.
REQ-033 With PIPE_STAGE_SKID_EN undefined: S is not built; in_ready = !M.valid | out_ready (combinational); FULL is unreachable; occupancy <= 1; the flush drop count is at most 2.

Structure
REQ-034 Package pipe_pkg holds the state enum (PIPE_EMPTY, PIPE_ONE, PIPE_FULL) and the default width constants for CTRL_W, DATA_W and CNT_W.
REQ-035 Sub-module pipe_slot implements one valid+ctrl+data register with load/clear; it is instantiated once for M and once for S (S under the macro).

Verification
REQ-036 Streaming test: rst, then in_valid=1 with out_ready=1 for 8 beats, data 0..7 -> out_data 0..7 one cycle later; occupancy stays at 1; no gaps.
REQ-037 Backpressure test: out_ready=0 while 3 beats are offered -> 2 accepted; in_ready=0 after the 2nd; occupancy=2; on release, beats exit in order.
REQ-038 Flush test: flush in FULL with Accept=0 and drop_cnt=5 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, drop_cnt=7.
REQ-039 Saturation test: drop_cnt=0xFFFE, then flush with 2 held beats -> drop_cnt=0xFFFF; a further flush leaves it at 0xFFFF.
REQ-040 Reset test: rst asserted in FULL while flush=1 -> all outputs at reset values and drop_cnt=0; first beat after reset is presented 1 cycle after its Accept.
REQ-041 Macro-off build: repeat REQ-036 and REQ-037 -> occupancy never exceeds 1; in_ready follows out_ready combinationally when M is valid.
